// File: rtl/sha3_scan_dispatcher.sv
// Job dispatcher for the SHA3 scanner: splits a nonce range into scanner-sized
// segments, starts the scanner only when idle, and returns one result per job.
module sha3_scan_dispatcher #(
  parameter  int PROPER         = 1,
  localparam int INPUT_ELEMENTS = (PROPER != 0) ? 20 : 24,
  parameter  int NONCE_SLOT     = INPUT_ELEMENTS - 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                job_valid,
  output logic                                job_ready,
  input  logic [INPUT_ELEMENTS-1:0][31:0]     job_blobby,
  input  logic [63:0]                         job_threshold,
  input  logic [31:0]                         job_first_nonce,
  input  logic [31:0]                         job_nonce_count,
  input  logic                                job_abort,
  output logic                                scan_start,
  output logic [INPUT_ELEMENTS-1:0][31:0]     scan_blobby,
  output logic [63:0]                         scan_threshold,
  input  logic                                scan_idle,
  input  logic                                scan_found,
  input  logic [24:0][63:0]                   scan_hash,
  input  logic [31:0]                         scan_nonce,
  input  logic                                scan_evaluating,
  input  logic [31:0]                         scan_count,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic                                res_found,
  output logic                                res_aborted,
  output logic [24:0][63:0]                   res_hash,
  output logic [31:0]                         res_nonce,
  output logic                                busy,
  output logic [63:0]                         hashes_tested
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_LEAVE, S_RUN, S_EVAL, S_REPORT
  } state_e;

  state_e                            state_q, state_d;
  logic [INPUT_ELEMENTS-1:0][31:0]   blob_q, blob_d;
  logic [63:0]                       thr_q, thr_d;
  logic [31:0]                       first_q, first_d;
  logic [31:0]                       count_q, count_d;
  logic [31:0]                       seg_q, seg_d;
  logic [31:0]                       rem_q, rem_d;
  logic                              abort_q, abort_d;
  logic                              found_q, found_d;
  logic                              aborted_q, aborted_d;
  logic [24:0][63:0]                 hash_q, hash_d;
  logic [31:0]                       nonce_q, nonce_d;
  logic [63:0]                       hashes_q, hashes_d;
  logic [31:0]                       off;
  logic                              hit;

  // Offset test rejects hits past the job range in the last partial segment.
  assign off = scan_nonce - first_q;
  assign hit = scan_found && (off < count_q);

  always_comb begin
    state_d   = state_q;
    blob_d    = blob_q;
    thr_d     = thr_q;
    first_d   = first_q;
    count_d   = count_q;
    seg_d     = seg_q;
    rem_d     = rem_q;
    abort_d   = abort_q;
    found_d   = found_q;
    aborted_d = aborted_q;
    hash_d    = hash_q;
    nonce_d   = nonce_q;
    hashes_d  = hashes_q + {63'd0, scan_evaluating};

    if (state_q != S_IDLE && job_abort) abort_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          blob_d             = job_blobby;
          blob_d[NONCE_SLOT] = job_first_nonce;
          thr_d              = job_threshold;
          first_d            = job_first_nonce;
          count_d            = job_nonce_count;
          seg_d              = job_first_nonce;
          rem_d              = job_nonce_count;
          abort_d            = 1'b0;
          found_d            = 1'b0;
          aborted_d          = 1'b0;
          hash_d             = '0;
          nonce_d            = '0;
          if (job_nonce_count == 32'd0 || scan_count == 32'd0) state_d = S_REPORT;
          else                                                 state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (scan_idle)  state_d = S_LEAVE;
      S_LEAVE: if (!scan_idle) state_d = S_RUN;
      S_RUN:   if (scan_idle)  state_d = S_EVAL;
      S_EVAL: begin
        if (hit) begin
          found_d = 1'b1;
          hash_d  = scan_hash;
          nonce_d = scan_nonce;
          state_d = S_REPORT;
        end else if (rem_q <= scan_count || abort_q) begin
          aborted_d = abort_q;
          state_d   = S_REPORT;
        end else begin
          rem_d              = rem_q - scan_count;
          seg_d              = seg_q + scan_count;
          blob_d[NONCE_SLOT] = seg_q + scan_count;
          state_d            = S_ISSUE;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          // Fields read as zero whenever no record is pending.
          found_d   = 1'b0;
          aborted_d = 1'b0;
          hash_d    = '0;
          nonce_d   = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      blob_q    <= '0;
      thr_q     <= '0;
      first_q   <= '0;
      count_q   <= '0;
      seg_q     <= '0;
      rem_q     <= '0;
      abort_q   <= 1'b0;
      found_q   <= 1'b0;
      aborted_q <= 1'b0;
      hash_q    <= '0;
      nonce_q   <= '0;
      hashes_q  <= '0;
    end else begin
      state_q   <= state_d;
      blob_q    <= blob_d;
      thr_q     <= thr_d;
      first_q   <= first_d;
      count_q   <= count_d;
      seg_q     <= seg_d;
      rem_q     <= rem_d;
      abort_q   <= abort_d;
      found_q   <= found_d;
      aborted_q <= aborted_d;
      hash_q    <= hash_d;
      nonce_q   <= nonce_d;
      hashes_q  <= hashes_d;
    end
  end

  assign job_ready      = !rst && (state_q == S_IDLE);
  assign scan_start     = !rst && (state_q == S_ISSUE) && scan_idle;
  assign scan_blobby    = blob_q;
  assign scan_threshold = thr_q;
  assign res_valid      = (state_q == S_REPORT);
  assign res_found      = found_q;
  assign res_aborted    = aborted_q;
  assign res_hash       = hash_q;
  assign res_nonce      = nonce_q;
  assign busy           = (state_q != S_IDLE);
  assign hashes_tested  = hashes_q;

endmodule

// File: tb/tb_sha3_scan_dispatcher.sv
// Directed bench for sha3_scan_dispatcher with a small behavioural scanner.
module tb_sha3_scan_dispatcher;
  localparam int IE   = 20;
  localparam int SLOT = IE - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 job_valid = 1'b0;
  logic                 job_ready;
  logic [IE-1:0][31:0]  job_blobby = '0;
  logic [63:0]          job_threshold = '0;
  logic [31:0]          job_first_nonce = '0;
  logic [31:0]          job_nonce_count = '0;
  logic                 job_abort = 1'b0;
  logic                 scan_start;
  logic [IE-1:0][31:0]  scan_blobby;
  logic [63:0]          scan_threshold;
  logic                 scan_idle;
  logic                 scan_found;
  logic [24:0][63:0]    scan_hash;
  logic [31:0]          scan_nonce;
  logic                 scan_evaluating;
  logic [31:0]          scan_count = 32'd256;
  logic                 res_valid;
  logic                 res_ready = 1'b1;
  logic                 res_found;
  logic                 res_aborted;
  logic [24:0][63:0]    res_hash;
  logic [31:0]          res_nonce;
  logic                 busy;
  logic [63:0]          hashes_tested;

  int total = 0;
  int bad   = 0;

  sha3_scan_dispatcher #(.PROPER(1)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_blobby(job_blobby),
    .job_threshold(job_threshold), .job_first_nonce(job_first_nonce),
    .job_nonce_count(job_nonce_count), .job_abort(job_abort),
    .scan_start(scan_start), .scan_blobby(scan_blobby), .scan_threshold(scan_threshold),
    .scan_idle(scan_idle), .scan_found(scan_found), .scan_hash(scan_hash),
    .scan_nonce(scan_nonce), .scan_evaluating(scan_evaluating), .scan_count(scan_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
    .res_aborted(res_aborted), .res_hash(res_hash), .res_nonce(res_nonce),
    .busy(busy), .hashes_tested(hashes_tested)
  );

  always #5 clk = ~clk;

  // Scanner model: one nonce per busy cycle, stops early on a hit.
  logic        m_busy, m_found, hit_en, idle_hold;
  logic [31:0] m_base, m_cnt, m_nonce, hit_nonce;
  initial begin hit_en = 1'b0; idle_hold = 1'b0; hit_nonce = '0; end

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_found <= 1'b0; m_base <= '0; m_cnt <= '0; m_nonce <= '0;
    end else if (scan_start) begin
      m_busy <= 1'b1; m_found <= 1'b0; m_base <= scan_blobby[SLOT]; m_cnt <= '0;
    end else if (m_busy) begin
      if (hit_en && (m_base + m_cnt) == hit_nonce) begin
        m_found <= 1'b1; m_nonce <= m_base + m_cnt; m_busy <= 1'b0;
      end else if (m_cnt == scan_count - 32'd1) begin
        m_busy <= 1'b0;
      end
      m_cnt <= m_cnt + 32'd1;
    end
  end

  assign scan_idle       = !m_busy && !idle_hold;
  assign scan_found      = m_found;
  assign scan_nonce      = m_nonce;
  assign scan_evaluating = m_busy;
  always_comb begin
    scan_hash = '0;
    for (int i = 0; i < 25; i++) scan_hash[i] = {m_nonce, 32'(i)};
  end

  int          starts = 0;
  int          viol   = 0;
  logic [31:0] segs[$];
  always @(negedge clk) begin
    if (scan_start) begin
      starts = starts + 1;
      segs.push_back(scan_blobby[SLOT]);
      if (!scan_idle) viol = viol + 1;
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; job_valid = 1'b0; job_abort = 1'b0;
    hit_en = 1'b0; idle_hold = 1'b0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic submit(input logic [31:0] first, input logic [31:0] cnt);
    @(negedge clk);
    for (int i = 0; i < IE; i++) job_blobby[i] = 32'h0101_0101 * i;
    job_threshold = 64'hDEAD_BEEF_0000_1234; job_first_nonce = first;
    job_nonce_count = cnt; job_valid = 1'b1;
    for (int i = 0; i < 100 && !job_ready; i++) @(negedge clk);
    @(negedge clk); job_valid = 1'b0;
  endtask

  task automatic wait_res(input string nm);
    int n = 0;
    while (!res_valid && n < 6000) begin @(negedge clk); n++; end
    total++;
    if (!res_valid) begin bad++; $display("FAIL %s timeout: res_valid=%b required 1", nm, res_valid); end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; @(negedge clk);
    total++; if (job_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got %b exp 0", job_ready); end
    rst = 1'b0; @(negedge clk);
    total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got %b exp 1", job_ready); end
    total++;
    if ({scan_start, res_valid, res_found, res_aborted, busy} !== 5'b0 || hashes_tested !== 64'd0 ||
        scan_blobby !== '0 || scan_threshold !== 64'd0 || res_hash !== '0 || res_nonce !== 32'd0) begin
      bad++; $display("FAIL reset_outputs got start=%b valid=%b busy=%b hashes=%0d exp all zero",
                      scan_start, res_valid, busy, hashes_tested);
    end
  endtask

  task automatic test_hit();
    int b;
    logic [24:0][63:0] eh;
    do_reset(); b = starts; hit_en = 1'b1; hit_nonce = 32'h1234_0105;
    submit(32'h1234_0000, 32'd1024);
    total++; if (scan_threshold !== 64'hDEAD_BEEF_0000_1234) begin bad++; $display("FAIL hit_thr got %h exp deadbeef00001234", scan_threshold); end
    wait_res("hit");
    for (int i = 0; i < 25; i++) eh[i] = {32'h1234_0105, 32'(i)};
    total++; if (res_found !== 1'b1 || res_nonce !== 32'h1234_0105) begin bad++; $display("FAIL hit_res got found=%b nonce=%h exp 1 12340105", res_found, res_nonce); end
    total++; if (res_hash !== eh) begin bad++; $display("FAIL hit_hash got w0=%h exp %h", res_hash[0], eh[0]); end
    total++; if (starts - b !== 2 || segs[b] !== 32'h1234_0000 || segs[b+1] !== 32'h1234_0100) begin
      bad++; $display("FAIL hit_segs got starts=%0d exp 2 seg0=12340000 seg1=12340100", starts - b); end
    total++; if (hashes_tested !== 64'd262) begin bad++; $display("FAIL hit_hashes got %0d exp 262", hashes_tested); end
    total++; if (scan_blobby[3] !== 32'h0303_0303) begin bad++; $display("FAIL hit_blob got %h exp 03030303", scan_blobby[3]); end
    @(negedge clk);
    total++; if (res_valid !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b1) begin bad++; $display("FAIL hit_done got valid=%b busy=%b exp 0 0", res_valid, busy); end
  endtask

  task automatic test_nohit();
    int b;
    do_reset(); b = starts;
    submit(32'h0000_1000, 32'd600);
    wait_res("nohit");
    total++; if (starts - b !== 3 || segs[b] !== 32'h1000 || segs[b+1] !== 32'h1100 || segs[b+2] !== 32'h1200) begin
      bad++; $display("FAIL nohit_segs got starts=%0d exp 3 at 1000/1100/1200", starts - b); end
    total++; if (res_found !== 1'b0 || res_aborted !== 1'b0 || res_nonce !== 32'd0) begin bad++; $display("FAIL nohit_res got found=%b ab=%b exp 0 0", res_found, res_aborted); end
    total++; if (hashes_tested !== 64'd768) begin bad++; $display("FAIL nohit_hashes got %0d exp 768", hashes_tested); end
  endtask

  task automatic test_out_of_range();
    do_reset(); hit_en = 1'b1; hit_nonce = 32'd700;
    submit(32'd0, 32'd600);
    wait_res("oor");
    total++; if (res_found !== 1'b0 || res_hash !== '0) begin bad++; $display("FAIL oor_found got %b exp 0", res_found); end
  endtask

  task automatic test_wrap();
    int b;
    do_reset(); b = starts;
    submit(32'hFFFF_FF80, 32'd512);
    wait_res("wrap");
    total++; if (starts - b !== 2 || segs[b+1] !== 32'h0000_0080) begin bad++; $display("FAIL wrap_seg got starts=%0d exp 2 seg1=00000080", starts - b); end
    total++; if (res_found !== 1'b0) begin bad++; $display("FAIL wrap_found got %b exp 0", res_found); end
  endtask

  task automatic test_empty_and_idle_hold();
    int b;
    do_reset(); b = starts;
    submit(32'd5, 32'd0);
    total++; if (res_valid !== 1'b1 || res_found !== 1'b0) begin bad++; $display("FAIL empty_res got valid=%b found=%b exp 1 0", res_valid, res_found); end
    @(negedge clk);
    total++; if (starts - b !== 0) begin bad++; $display("FAIL empty_starts got %0d exp 0", starts - b); end
    idle_hold = 1'b1; b = starts;
    submit(32'h100, 32'd256);
    repeat (50) @(negedge clk);
    total++; if (starts - b !== 0) begin bad++; $display("FAIL hold_starts got %0d exp 0", starts - b); end
    idle_hold = 1'b0;
    wait_res("hold");
    total++; if (starts - b !== 1 || viol !== 0) begin bad++; $display("FAIL hold_done got starts=%0d viol=%0d exp 1 0", starts - b, viol); end
  endtask

  task automatic test_abort();
    int b, n;
    do_reset(); b = starts;
    submit(32'h2000, 32'd1024);
    n = 0;
    while (starts - b < 2 && n < 2000) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    job_abort = 1'b1; repeat (3) @(negedge clk); job_abort = 1'b0;
    wait_res("abort");
    total++; if (res_aborted !== 1'b1 || res_found !== 1'b0) begin bad++; $display("FAIL abort_res got ab=%b found=%b exp 1 0", res_aborted, res_found); end
    total++; if (starts - b !== 2 || hashes_tested !== 64'd512) begin bad++; $display("FAIL abort_segs got starts=%0d hashes=%0d exp 2 512", starts - b, hashes_tested); end
  endtask

  task automatic test_rst_run();
    int b, n;
    do_reset(); b = starts;
    submit(32'h3000, 32'd1024);
    n = 0;
    while (starts == b && n < 200) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    rst = 1'b1; @(negedge clk);
    total++;
    if ({job_ready, scan_start, res_valid, busy} !== 4'b0 || hashes_tested !== 64'd0 ||
        scan_blobby !== '0 || scan_threshold !== 64'd0) begin
      bad++; $display("FAIL rst_run got ready=%b start=%b valid=%b busy=%b hashes=%0d exp all 0",
                      job_ready, scan_start, res_valid, busy, hashes_tested);
    end
    rst = 1'b0; @(negedge clk);
    total++; if (job_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_run_idle got ready=%b busy=%b exp 1 0", job_ready, busy); end
  endtask

  task automatic test_back_pressure();
    do_reset(); hit_en = 1'b1; hit_nonce = 32'h4010; res_ready = 1'b0;
    submit(32'h4000, 32'd256);
    wait_res("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (res_valid !== 1'b1 || res_found !== 1'b1 || res_nonce !== 32'h4010 || res_hash[7] !== {32'h4010, 32'd7}) begin
        bad++; $display("FAIL bp_stable cyc=%0d got valid=%b nonce=%h exp 1 00004010", i, res_valid, res_nonce);
      end
    end
    res_ready = 1'b1; @(negedge clk);
    total++; if (res_valid !== 1'b0 || res_nonce !== 32'd0) begin bad++; $display("FAIL bp_release got valid=%b nonce=%h exp 0 0", res_valid, res_nonce); end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_nohit();
    test_out_of_range();
    test_wrap();
    test_empty_and_idle_hold();
    test_abort();
    test_rst_run();
    test_back_pressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sha3_scan_dispatcher.md
Name: sha3_scan_dispatcher

Overview:
Work-feeding controller on the initiator side of the scanner handshake. It accepts one mining job per handshake, cuts the job's nonce range into scanner-sized segments, and strobes the scanner's start only when the scanner reports idle. It collects the found/hash/nonce result after each segment and returns exactly one result record per job. It sits between the AXI register/command layer and the scanner instantiator, sharing that block's clock.

Parameters:
PROPER, 1, selects scanner input layout; INPUT_ELEMENTS = PROPER ? 20 : 24 (localparam).
NONCE_SLOT, INPUT_ELEMENTS-1, index of the blobby word overwritten with the segment's first nonce.

Ports:
clk  in  1  single clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
job_valid  in  1  job offered.
job_ready  out  1  dispatcher can accept a job.
job_blobby  in  32 x INPUT_ELEMENTS  header words.
job_threshold  in  64  difficulty threshold.
job_first_nonce  in  32  first nonce of range.
job_nonce_count  in  32  nonces to test; 0 = empty range.
job_abort  in  1  level; stop after current segment.
scan_start  out  1  one-cycle start strobe to scanner.
scan_blobby  out  32 x INPUT_ELEMENTS  registered job words, NONCE_SLOT = segment nonce.
scan_threshold  out  64  registered threshold.
scan_idle  in  1  scanner idle.
scan_found  in  1  scanner result valid.
scan_hash  in  64 x 25  scanner hash.
scan_nonce  in  32  scanner nonce.
scan_evaluating  in  1  one hash tested this cycle.
scan_count  in  32  nonces per scanner start (constant).
res_valid  out  1  result record valid.
res_ready  in  1  consumer accepts record.
res_found  out  1  record carries an in-range hit.
res_aborted  out  1  job ended by job_abort.
res_hash  out  64 x 25  hit hash (all zero when !res_found).
res_nonce  out  32  hit nonce (0 when !res_found).
busy  out  1  job in flight or record pending.
hashes_tested  out  64  running count of scan_evaluating cycles; wraps mod 2^64.

Behaviour:
- Reset values: job_ready=0 during rst, then 1 in IDLE. scan_start=0, scan_blobby/scan_threshold/res_hash=0, res_valid=0, res_found=0, res_aborted=0, res_nonce=0, busy=0, hashes_tested=0. State=IDLE.
- Reset mid-operation: drop everything to IDLE and discard any pending record. The scanner is reset by the same rst. Any held job_abort is ignored until the next accept.
- State IDLE: job_ready=1. Acceptance requires job_valid&job_ready.
  - On accept, latch blobby, threshold, first_nonce as seg_nonce, count as remaining, and clear the abort flag. job_ready=0 next cycle; busy=1.
  - If count==0 or scan_count==0, go to REPORT with res_found=0.
  - Otherwise go to ISSUE.
- State ISSUE: load scan_blobby with seg_nonce at NONCE_SLOT. Wait for scan_idle=1, then assert scan_start for exactly one cycle and go to LEAVE. scan_start is never asserted while scan_idle=0.
- State LEAVE: wait for scan_idle=0, then go to RUN.
- State RUN: wait for scan_idle=1, then go to EVAL.
- State EVAL (one cycle):
  - Compute off = scan_nonce - first_nonce (mod 2^32).
  - hit = scan_found & (off < job_nonce_count).
  - If hit: capture scan_hash/scan_nonce and go to REPORT with res_found=1.
  - Else, if remaining <= scan_count or the abort flag is set: go to REPORT with res_found=0.
  - Else: remaining -= scan_count, seg_nonce += scan_count (wraps mod 2^32), go to ISSUE.
  - Out-of-range hits (last partial segment) are discarded.
- Abort: job_abort sampled in any non-IDLE state sets a sticky flag. The current segment always completes, and a hit in that segment still reports res_found=1. res_aborted = flag when no hit.
- State REPORT: res_valid=1, with fields stable until res_ready. On res_valid&res_ready go to IDLE, res_valid=0 next cycle. Accepting a new job is possible the cycle after.
- hashes_tested increments on every cycle scan_evaluating=1, in any state. It is not cleared by jobs, only by rst.
- scan_threshold updates only on job accept.

Test Plan:
- Behavioural scanner model, scan_count=256, hit at nonce 0x1234_0105; job first_nonce=0x1234_0000, count=1024 -> starts at 0x12340000 and 0x12340100, res_found=1, res_nonce=0x12340105, exactly 2 scan_start pulses.
- No hit, count=600, scan_count=256 -> 3 starts (seg nonces +0, +256, +512), res_found=0, res_aborted=0, hashes_tested=768.
- Last-segment hit at offset 700 with count=600 -> hit discarded, res_found=0.
- first_nonce=0xFFFF_FF80, count=512 -> second segment nonce 0x0000_0080 (wrap), no spurious done.
- count=0 -> no scan_start, res_valid within 2 cycles with res_found=0. scan_idle held low 50 cycles before a job -> start delayed until idle.
- Assert job_abort mid-segment of a 4-segment job -> segment finishes, res_aborted=1. rst during RUN -> all outputs return to reset values next cycle. res_ready held low 10 cycles -> record fields stable.
